// File: rtl/bram_boot_sequencer.sv
// Boot/run controller: streams a program image into BRAM port A with the core held in reset,
// then releases the core onto port A and flags completion on a write to the DONE address.
module bram_boot_sequencer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int NB_COL          = 4,
    parameter int COL_WIDTH       = 8,
    parameter int RST_HOLD_CYCLES = 8,
    parameter int DONE_ADDR       = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [NB_COL*COL_WIDTH-1:0]   s_data,
    input  logic                          s_last,
    input  logic [ADDR_WIDTH-1:0]         i_core_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   i_core_wr_data,
    input  logic [NB_COL-1:0]             i_core_wr_en,
    output logic [NB_COL*COL_WIDTH-1:0]   o_core_rd_data,
    output logic [ADDR_WIDTH-1:0]         o_bram_addr,
    output logic [NB_COL*COL_WIDTH-1:0]   o_bram_wr_data,
    output logic [NB_COL-1:0]             o_bram_wr_en,
    input  logic [NB_COL*COL_WIDTH-1:0]   i_bram_rd_data,
    output logic                          o_core_reset,
    output logic                          o_done,
    output logic                          o_load_err
);

    // state  | meaning
    // LOAD   | accepting image beats into BRAM, core held in reset
    // HOLD   | image loaded, core reset held for RST_HOLD_CYCLES
    // RUN    | core owns port A, watching for the DONE write
    // DONE   | program finished, core back in reset, port A writes blocked
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]         HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] DONE_A    = ADDR_WIDTH'(DONE_ADDR);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  load_err_q, load_err_d;

    always_comb begin
        state_d        = state_q;
        load_addr_d    = load_addr_q;
        hold_cnt_d     = hold_cnt_q;
        core_reset_d   = core_reset_q;
        done_d         = done_q;
        load_err_d     = load_err_q;
        s_ready        = 1'b0;
        o_bram_addr    = load_addr_q;
        o_bram_wr_data = s_data;
        o_bram_wr_en   = '0;

        case (state_q)
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    o_bram_wr_en = '1;
                    // The top word ends the load even without s_last; the address never wraps.
                    if (s_last || load_addr_q == ADDR_MAX) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                        if (!s_last) load_err_d = 1'b1;
                    end
                    if (load_addr_q != ADDR_MAX) load_addr_d = load_addr_q + ADDR_WIDTH'(1);
                end
            end
            S_HOLD: begin
                core_reset_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = S_RUN;
                    core_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                o_bram_addr    = i_core_addr;
                o_bram_wr_data = i_core_wr_data;
                o_bram_wr_en   = i_core_wr_en;
                if ((|i_core_wr_en) && i_core_addr == DONE_A) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    core_reset_d = 1'b1;
                end
            end
            S_DONE: begin
                o_bram_addr    = i_core_addr;
                o_bram_wr_data = i_core_wr_data;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            load_addr_q  <= '0;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_addr_q  <= load_addr_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign o_core_rd_data = i_bram_rd_data;
    assign o_core_reset   = core_reset_q;
    assign o_done         = done_q;
    assign o_load_err     = load_err_q;

endmodule

// File: tb/tb_bram_boot_sequencer.sv
// Randomized bench for bram_boot_sequencer: a BRAM model on port A plus a reference image
// of expected memory contents and expected handshake/timing behaviour.
module tb_bram_boot_sequencer;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NB   = 4;
    localparam int HOLD = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic [AW-1:0] i_core_addr;
    logic [DW-1:0] i_core_wr_data;
    logic [NB-1:0] i_core_wr_en;
    logic [DW-1:0] o_core_rd_data;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_wr_data;
    logic [NB-1:0] o_bram_wr_en;
    logic [DW-1:0] i_bram_rd_data;
    logic          o_core_reset, o_done, o_load_err;

    logic [DW-1:0] bram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_boot_sequencer #(
        .ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(8),
        .RST_HOLD_CYCLES(HOLD), .DONE_ADDR(1023)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .i_core_addr(i_core_addr), .i_core_wr_data(i_core_wr_data), .i_core_wr_en(i_core_wr_en),
        .o_core_rd_data(o_core_rd_data),
        .o_bram_addr(o_bram_addr), .o_bram_wr_data(o_bram_wr_data), .o_bram_wr_en(o_bram_wr_en),
        .i_bram_rd_data(i_bram_rd_data),
        .o_core_reset(o_core_reset), .o_done(o_done), .o_load_err(o_load_err)
    );

    // Byte-enabled BRAM port A, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (o_bram_wr_en[b]) bram_mem[o_bram_addr][8*b +: 8] <= o_bram_wr_data[8*b +: 8];
        i_bram_rd_data <= bram_mem[o_bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        i_core_addr = '0; i_core_wr_data = '0; i_core_wr_en = '0;
    endtask

    task automatic do_reset(input int ncyc);
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < ncyc; i++) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(s_ready), 64'(1));
        chk("rst_core_reset", 64'(o_core_reset), 64'(1));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_err", 64'(o_load_err), 64'(0));
        chk("rst_addr", 64'(o_bram_addr), 64'(0));
        chk("rst_wren", 64'(o_bram_wr_en), 64'(0));
        step();
    endtask

    // vprob < 0: s_valid alternates each cycle; otherwise percent chance of valid.
    task automatic load_stream(input int n, input int vprob, input bit use_last, input bit seq_data);
        int beats = 0;
        int cyc = 0;
        logic v;
        logic [DW-1:0] d;
        while (beats < n && cyc < 8000) begin
            v = (vprob < 0) ? cyc[0] : ($urandom_range(99) < vprob);
            d = seq_data ? DW'(32'h11 * (beats + 1)) : $urandom;
            s_valid = v; s_data = d; s_last = use_last && (beats == n - 1);
            i_core_addr = AW'($urandom); i_core_wr_en = NB'($urandom); i_core_wr_data = $urandom;
            @(negedge clk);
            chk("ld_ready", 64'(s_ready), 64'(1));
            chk("ld_core_reset", 64'(o_core_reset), 64'(1));
            chk("ld_wren", 64'(o_bram_wr_en), v ? 64'hF : 64'h0);
            chk("ld_addr", 64'(o_bram_addr), 64'(beats));
            if (v) begin
                chk("ld_data", 64'(o_bram_wr_data), 64'(d));
                ref_mem[beats] = d;
                beats++;
            end
            step();
            cyc++;
        end
        if (cyc >= 8000) chk("ld_timeout", 64'(0), 64'(1));
        idle_inputs();
    endtask

    // Core reset must stay high exactly HOLD cycles after the final beat; stray beats are refused.
    task automatic check_hold(input bit exp_err);
        int cnt = 0;
        bit released = 1'b0;
        for (int i = 0; i < HOLD + 4 && !released; i++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
            @(negedge clk);
            if (o_core_reset) begin
                chk("hold_ready", 64'(s_ready), 64'(0));
                chk("hold_wren", 64'(o_bram_wr_en), 64'(0));
                chk("hold_err", 64'(o_load_err), 64'(exp_err));
                cnt++;
                step();
            end else begin
                released = 1'b1;
            end
        end
        chk("hold_len", 64'(cnt), 64'(HOLD));
        idle_inputs();
        step();
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < n; i++) chk($sformatf("mem_%0d", i), 64'(bram_mem[i]), 64'(ref_mem[i]));
    endtask

    // One core cycle while running: port A follows the core, read data lags one cycle.
    logic [DW-1:0] exp_rd;
    bit have_prev;
    task automatic core_cycle(input logic [AW-1:0] a, input logic [NB-1:0] en, input logic [DW-1:0] d,
                              input bit exp_err);
        i_core_addr = a; i_core_wr_en = en; i_core_wr_data = d;
        s_valid = $urandom_range(1); s_data = $urandom;
        @(negedge clk);
        chk("run_addr", 64'(o_bram_addr), 64'(a));
        chk("run_wren", 64'(o_bram_wr_en), 64'(en));
        chk("run_wdata", 64'(o_bram_wr_data), 64'(d));
        chk("run_core_reset", 64'(o_core_reset), 64'(0));
        chk("run_done", 64'(o_done), 64'(0));
        chk("run_ready", 64'(s_ready), 64'(0));
        chk("run_err", 64'(o_load_err), 64'(exp_err));
        if (have_prev) chk("run_rdata", 64'(o_core_rd_data), 64'(exp_rd));
        exp_rd = ref_mem[a];
        have_prev = 1'b1;
        for (int b = 0; b < NB; b++) if (en[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        step();
    endtask

    task automatic run_random(input int n, input bit exp_err);
        logic [AW-1:0] a;
        logic [NB-1:0] en;
        have_prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            a  = AW'($urandom_range(DEPTH - 2));
            en = NB'($urandom);
            if ($urandom_range(3) == 0) begin a = AW'(DEPTH - 1); en = '0; end
            core_cycle(a, en, $urandom, exp_err);
        end
    endtask

    task automatic finish_program();
        logic [NB-1:0] en;
        core_cycle(AW'(DEPTH - 1), NB'($urandom_range(15, 1)), $urandom, 1'b0);
        @(negedge clk);
        chk("done_flag", 64'(o_done), 64'(1));
        chk("done_core_reset", 64'(o_core_reset), 64'(1));
        step();
        for (int i = 0; i < 6; i++) begin
            en = NB'($urandom_range(15, 1));
            i_core_addr = AW'($urandom); i_core_wr_en = en; i_core_wr_data = $urandom;
            s_valid = 1'b1;
            @(negedge clk);
            chk("post_wren", 64'(o_bram_wr_en), 64'(0));
            chk("post_addr", 64'(o_bram_addr), 64'(i_core_addr));
            chk("post_done", 64'(o_done), 64'(1));
            chk("post_core_reset", 64'(o_core_reset), 64'(1));
            chk("post_ready", 64'(s_ready), 64'(0));
            step();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1;
        idle_inputs();

        // Directed 4-word image, directed core write, read of DONE address, completion.
        do_reset(2);
        load_stream(4, 100, 1'b1, 1'b1);
        check_hold(1'b0);
        check_mem(4);
        chk("img_word0", 64'(bram_mem[0]), 64'h11);
        chk("img_word3", 64'(bram_mem[3]), 64'h44);
        have_prev = 1'b0;
        core_cycle(AW'(5), 4'h3, 32'hDEADBEEF, 1'b0);
        core_cycle(AW'(DEPTH - 1), 4'h0, 32'h0, 1'b0);
        core_cycle(AW'(5), 4'h0, 32'h0, 1'b0);
        core_cycle(AW'(0), 4'h0, 32'h0, 1'b0);
        run_random(20, 1'b0);
        finish_program();
        check_mem(8);

        // Gappy valid, then random-probability valid.
        do_reset(1);
        load_stream(20, -1, 1'b1, 1'b0);
        check_hold(1'b0);
        check_mem(20);
        run_random(40, 1'b0);
        finish_program();

        do_reset(3);
        load_stream(13, 60, 1'b1, 1'b0);
        check_hold(1'b0);
        check_mem(13);
        run_random(30, 1'b0);

        // Reset mid-load restarts at address 0.
        do_reset(1);
        load_stream(2, 100, 1'b0, 1'b0);
        do_reset(1);
        load_stream(4, 70, 1'b1, 1'b0);
        check_hold(1'b0);
        check_mem(4);

        // Overflow: full-depth image without s_last.
        do_reset(2);
        load_stream(DEPTH, 100, 1'b0, 1'b0);
        check_hold(1'b1);
        chk("ovf_err", 64'(o_load_err), 64'(1));
        check_mem(DEPTH);
        run_random(10, 1'b1);
        do_reset(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
